// File: rtl/sda_fir_sequencer.sv
// Sample scheduler for the bit-serial DA FIR core: input FIFO, load/shift/capture
// sequencing for the serial core, and a backpressured result register.
module sda_fir_sequencer #(
  parameter int DATA_W     = 8,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        RstN,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DATA_W-1:0]    in_data,
  output logic                        core_load,
  output logic signed [DATA_W-1:0]    core_x,
  output logic                        core_shift,
  output logic [$clog2(DATA_W)-1:0]   core_bit_idx,
  output logic                        core_msb,
  input  logic signed [OUT_W-1:0]     core_y,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_W-1:0]     out_data,
  output logic                        busy,
  output logic [15:0]                 sample_cnt
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic signed [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [PTR_W:0]           r_count;
  logic signed [DATA_W-1:0] r_x;
  logic [BIT_W-1:0]         r_bit;
  logic                     r_out_valid;
  logic signed [OUT_W-1:0]  r_out_data;
  logic [15:0]              r_cnt;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_capture;
  logic w_last_bit;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_last_bit = (r_bit == LAST_BIT);
  // A push during flush is dropped; the full check keeps in_valid off every output path.
  assign w_push     = in_valid && !w_full && !flush;
  assign w_capture  = (r_state == S_DONE) && (!r_out_valid || out_ready);
  // DONE pops directly into LOAD so streaming never passes through IDLE.
  assign w_pop      = !flush && !w_empty && ((r_state == S_IDLE) || w_capture);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (!w_empty) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last_bit) w_state_nxt = S_DONE;
      S_DONE:  if (w_capture) w_state_nxt = w_empty ? S_IDLE : S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge RstN) begin
    if (!RstN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge RstN) begin
    if (!RstN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PTR_W + 1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge RstN) begin
    if (!RstN) begin
      r_x   <= '0;
      r_bit <= '0;
    end else begin
      if (w_pop) r_x <= r_mem[r_rd_ptr];
      if (flush || r_state == S_LOAD) begin
        r_bit <= '0;
      end else if (r_state == S_SHIFT) begin
        r_bit <= w_last_bit ? '0 : r_bit + BIT_W'(1);
      end
    end
  end

  // A capture and an acceptance in the same cycle leave out_valid set with new data.
  always_ff @(posedge clk or negedge RstN) begin
    if (!RstN) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_cnt       <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_data  <= core_y;
      r_cnt       <= r_cnt + 16'd1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready     = !w_full;
  assign core_load    = (r_state == S_LOAD);
  assign core_x       = r_x;
  assign core_shift   = (r_state == S_SHIFT);
  assign core_bit_idx = r_bit;
  assign core_msb     = (r_state == S_SHIFT) && w_last_bit;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign busy         = (r_state != S_IDLE);
  assign sample_cnt   = r_cnt;

endmodule

// File: tb/tb_sda_fir_sequencer.sv
// Bench for sda_fir_sequencer: a behavioural serial-core stand-in plus
// scenario tasks comparing delivered results against y = 37*x + 100.
module tb_sda_fir_sequencer;

  logic               clk = 1'b0;
  logic               RstN = 1'b0;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [7:0]  in_data = '0;
  logic               core_load;
  logic signed [7:0]  core_x;
  logic               core_shift;
  logic [2:0]         core_bit_idx;
  logic               core_msb;
  logic signed [15:0] core_y;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_data;
  logic               busy;
  logic [15:0]        sample_cnt;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  logic [15:0] act_rx[$];
  int          load_q[$];
  logic signed [7:0] core_tap;

  sda_fir_sequencer #(.DATA_W(8), .OUT_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .RstN(RstN), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .core_load(core_load), .core_x(core_x), .core_shift(core_shift),
    .core_bit_idx(core_bit_idx), .core_msb(core_msb), .core_y(core_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] filt(input logic signed [7:0] x);
    int v;
    v = int'(x) * 37 + 100;
    return v[15:0];
  endfunction

  // Serial core stand-in: result is garbage until the sign-bit cycle has been seen.
  always @(posedge clk or negedge RstN) begin
    if (!RstN) begin
      core_tap <= '0;
      core_y   <= '0;
    end else if (core_load) begin
      core_tap <= core_x;
      core_y   <= 16'sh5A5A;
    end else if (core_shift && core_msb) begin
      core_y   <= filt(core_tap);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_load) load_q.push_back(cyc);
    if (RstN && !flush && out_valid && out_ready) act_rx.push_back(out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    act_rx.delete();
    load_q.delete();
  endtask

  task automatic drive_push(input logic signed [7:0] x, output bit ok);
    int g = 0;
    in_data  = x;
    in_valid = 1'b1;
    while (!in_ready && g < 200) begin
      tick();
      g++;
    end
    ok = in_ready;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    RstN = 1'b0;
    tick();
    nvec++;
    if ({in_ready, out_valid, core_load, core_shift, core_msb, busy} !== 6'b100000) begin
      nerr++;
      $display("FAIL reset_ctrl: got %b expected 100000",
               {in_ready, out_valid, core_load, core_shift, core_msb, busy});
    end
    nvec++;
    if (out_data !== 16'sd0) begin nerr++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    nvec++;
    if (core_x !== 8'sd0) begin nerr++; $display("FAIL reset_core_x: got %0d expected 0", core_x); end
    nvec++;
    if (core_bit_idx !== 3'd0) begin nerr++; $display("FAIL reset_bit_idx: got %0d expected 0", core_bit_idx); end
    nvec++;
    if (sample_cnt !== 16'd0) begin nerr++; $display("FAIL reset_sample_cnt: got %0d expected 0", sample_cnt); end
    RstN = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int loads = 0, load_k = -1, shifts = 0, bad_idx = 0, msbs = 0, first_ov = -1;
    logic signed [7:0] lx = '0;
    do_flush();
    out_ready = 1'b0;
    in_data   = 8'sd127;
    in_valid  = 1'b1;
    nvec++;
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (core_load) begin loads++; load_k = k; lx = core_x; end
      if (core_shift) begin
        if (core_bit_idx !== 3'(shifts)) bad_idx++;
        if (core_msb) begin msbs++; if (core_bit_idx !== 3'd7) bad_idx++; end
        shifts++;
      end
      if (out_valid && first_ov < 0) first_ov = k;
    end
    nvec++;
    if (loads !== 1 || load_k !== 1) begin nerr++; $display("FAIL single_load: got %0d pulses at %0d expected 1 at 1", loads, load_k); end
    nvec++;
    if (lx !== 8'sd127) begin nerr++; $display("FAIL single_core_x: got %0d expected 127", lx); end
    nvec++;
    if (shifts !== 8 || bad_idx !== 0 || msbs !== 1) begin
      nerr++;
      $display("FAIL single_shift: got %0d shifts %0d bad %0d msb expected 8 0 1", shifts, bad_idx, msbs);
    end
    nvec++;
    if (first_ov !== 11) begin nerr++; $display("FAIL single_latency: got %0d expected 11", first_ov); end
    nvec++;
    if (out_data !== filt(8'sd127)) begin nerr++; $display("FAIL single_data: got %0d expected %0d", out_data, filt(8'sd127)); end
    nvec++;
    if (sample_cnt !== 16'd1) begin nerr++; $display("FAIL single_cnt: got %0d expected 1", sample_cnt); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    nvec++;
    if (out_valid !== 1'b0 || act_rx.size() !== 1) begin
      nerr++;
      $display("FAIL single_accept: got valid %b rx %0d expected 0 1", out_valid, act_rx.size());
    end
  endtask

  task automatic test_back_to_back();
    logic signed [7:0] tab[177];
    int i = 0, g = 0, bad = 0;
    real r;
    for (int k = 0; k < 177; k++) begin
      r = 120.0 * $sin(2.0 * 3.14159265 * k / 32.0);
      tab[k] = 8'($rtoi(r));
    end
    do_flush();
    out_ready = 1'b1;
    while (i < 177 && g < 5000) begin
      in_data  = tab[i];
      in_valid = 1'b1;
      if (in_ready) i++;
      tick();
      g++;
    end
    in_valid = 1'b0;
    nvec++;
    if (i !== 177) begin nerr++; $display("FAIL b2b_push: got %0d expected 177", i); end
    g = 0;
    while (act_rx.size() < 177 && g < 3000) begin tick(); g++; end
    tick();
    nvec++;
    if (act_rx.size() !== 177) begin nerr++; $display("FAIL b2b_count: got %0d expected 177", act_rx.size()); end
    for (int k = 0; k < 177 && k < act_rx.size(); k++) begin
      nvec++;
      if (act_rx[k] !== filt(tab[k])) begin
        nerr++;
        $display("FAIL b2b_data[%0d]: got %0d expected %0d", k, act_rx[k], filt(tab[k]));
      end
    end
    for (int k = 1; k < load_q.size(); k++)
      if (load_q[k] - load_q[k-1] != 10) bad++;
    nvec++;
    if (load_q.size() !== 177 || bad !== 0) begin
      nerr++;
      $display("FAIL b2b_spacing: got %0d loads %0d bad gaps expected 177 0", load_q.size(), bad);
    end
    nvec++;
    if (sample_cnt !== 16'd177) begin nerr++; $display("FAIL b2b_cnt: got %0d expected 177", sample_cnt); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic signed [7:0] s[6];
    int i = 0, g = 0;
    bit saw_full = 0;
    for (int k = 0; k < 6; k++) s[k] = 8'($urandom);
    do_flush();
    out_ready = 1'b0;
    while (i < 6 && g < 300) begin
      in_data  = s[i];
      in_valid = 1'b1;
      if (in_ready) i++;
      else saw_full = 1;
      tick();
      g++;
    end
    in_valid = 1'b0;
    repeat (20) tick();
    nvec++;
    if (i !== 6 || !saw_full) begin nerr++; $display("FAIL bp_push: got %0d pushed full=%0d expected 6 1", i, saw_full); end
    nvec++;
    if ({busy, core_load, core_shift, out_valid, in_ready} !== 5'b10010) begin
      nerr++;
      $display("FAIL bp_stall: got %b expected 10010", {busy, core_load, core_shift, out_valid, in_ready});
    end
    nvec++;
    if (out_data !== filt(s[0]) || sample_cnt !== 16'd1) begin
      nerr++;
      $display("FAIL bp_head: got %0d cnt %0d expected %0d cnt 1", out_data, sample_cnt, filt(s[0]));
    end
    out_ready = 1'b1;
    g = 0;
    while (act_rx.size() < 6 && g < 200) begin tick(); g++; end
    repeat (3) tick();
    nvec++;
    if (act_rx.size() !== 6 || sample_cnt !== 16'd6) begin
      nerr++;
      $display("FAIL bp_count: got %0d rx cnt %0d expected 6 6", act_rx.size(), sample_cnt);
    end
    for (int k = 0; k < 6 && k < act_rx.size(); k++) begin
      nvec++;
      if (act_rx[k] !== filt(s[k])) begin nerr++; $display("FAIL bp_data[%0d]: got %0d expected %0d", k, act_rx[k], filt(s[k])); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_boundary();
    logic signed [7:0] s[6];
    bit ok;
    int g = 0;
    for (int k = 0; k < 6; k++) s[k] = 8'($urandom);
    do_flush();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_push(s[k], ok);
      nvec++;
      if (!ok) begin nerr++; $display("FAIL fb_push[%0d]: got timeout expected accept", k); end
    end
    in_data  = s[5];
    in_valid = 1'b1;
    while (!(busy && !core_load && !core_shift) && g < 100) begin tick(); g++; end
    nvec++;
    if (in_ready !== 1'b0) begin nerr++; $display("FAIL fb_done_ready: got %b expected 0", in_ready); end
    tick();
    nvec++;
    if (core_load !== 1'b1 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL fb_pop: got load %b ready %b expected 1 1", core_load, in_ready);
    end
    tick();
    in_valid = 1'b0;
    nvec++;
    if (in_ready !== 1'b0) begin nerr++; $display("FAIL fb_occupancy: got ready %b expected 0", in_ready); end
    g = 0;
    while (act_rx.size() < 6 && g < 200) begin tick(); g++; end
    repeat (3) tick();
    nvec++;
    if (act_rx.size() !== 6) begin nerr++; $display("FAIL fb_count: got %0d expected 6", act_rx.size()); end
    for (int k = 0; k < 6 && k < act_rx.size(); k++) begin
      nvec++;
      if (act_rx[k] !== filt(s[k])) begin nerr++; $display("FAIL fb_data[%0d]: got %0d expected %0d", k, act_rx[k], filt(s[k])); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush_mid_shift();
    bit ok;
    int g = 0, loads = 0;
    logic signed [7:0] x0;
    x0 = 8'($urandom);
    do_flush();
    out_ready = 1'b1;
    drive_push(x0, ok);
    while (act_rx.size() < 1 && g < 100) begin tick(); g++; end
    nvec++;
    if (act_rx.size() !== 1 || act_rx[0] !== filt(x0)) begin
      nerr++;
      $display("FAIL fl_first: got %0d results expected 1 of %0d", act_rx.size(), filt(x0));
    end
    for (int k = 0; k < 3; k++) drive_push(8'($urandom), ok);
    g = 0;
    while (!(core_shift && core_bit_idx == 3'd3) && g < 100) begin tick(); g++; end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    nvec++;
    if ({busy, in_ready, out_valid, core_shift} !== 4'b0100 || sample_cnt !== 16'd0) begin
      nerr++;
      $display("FAIL fl_state: got %b cnt %0d expected 0100 cnt 0", {busy, in_ready, out_valid, core_shift}, sample_cnt);
    end
    for (int k = 0; k < 30; k++) begin
      if (core_load) loads++;
      tick();
    end
    nvec++;
    if (loads !== 0 || act_rx.size() !== 1) begin
      nerr++;
      $display("FAIL fl_quiet: got %0d loads %0d results expected 0 1", loads, act_rx.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bit ok;
    int g = 0, first_ov = -1;
    do_flush();
    out_ready = 1'b1;
    drive_push(8'($urandom), ok);
    while (act_rx.size() < 1 && g < 100) begin tick(); g++; end
    drive_push(8'sd55, ok);
    g = 0;
    while (!core_shift && g < 100) begin tick(); g++; end
    #2;
    RstN = 1'b0;
    #1;
    nvec++;
    if ({busy, core_shift, core_load, core_msb, in_ready, out_valid} !== 6'b000010) begin
      nerr++;
      $display("FAIL ar_ctrl: got %b expected 000010", {busy, core_shift, core_load, core_msb, in_ready, out_valid});
    end
    nvec++;
    if (sample_cnt !== 16'd0 || core_x !== 8'sd0 || core_bit_idx !== 3'd0 || out_data !== 16'sd0) begin
      nerr++;
      $display("FAIL ar_data: got cnt %0d x %0d idx %0d out %0d expected all 0", sample_cnt, core_x, core_bit_idx, out_data);
    end
    @(negedge clk);
    RstN = 1'b1;
    tick();
    out_ready = 1'b0;
    in_data   = 8'sd0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (out_valid && first_ov < 0) first_ov = k;
    end
    nvec++;
    if (first_ov !== 11 || out_data !== filt(8'sd0)) begin
      nerr++;
      $display("FAIL ar_restart: got at %0d data %0d expected at 11 data %0d", first_ov, out_data, filt(8'sd0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_boundary();
    test_flush_mid_shift();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sda_fir_sequencer.md
# sda_fir_sequencer

Sample scheduler for the bit-serial distributed-arithmetic FIR core. It accepts 8-bit signed samples over a valid/ready handshake and buffers them in a small FIFO. For each sample it runs the fixed load/shift/capture sequence the serial core needs, then presents each filtered result on a valid/ready output port with backpressure. It replaces free-running delay counters between the sample source and the FIR core.

## Interface
- DATA_W, 8: input sample width, and the number of serial bit cycles per sample
- OUT_W, 16: filter result width
- FIFO_DEPTH, 4: input FIFO entries (power of two, ≥2)
- clk  in  1  system clock; all logic on rising edge
- RstN  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of FIFO, FSM and output register
- in_valid  in  1  sample offered
- in_ready  out  1  FIFO not full
- in_data  in  DATA_W  signed sample
- core_load  out  1  one-cycle strobe: core latches core_x into its tap line
- core_x  out  DATA_W  sample being processed, held stable LOAD through SHIFT
- core_shift  out  1  core processes bit core_bit_idx this cycle
- core_bit_idx  out  log2(DATA_W)  bit index, 0 = LSB
- core_msb  out  1  high on the sign-bit cycle; core subtracts the partial sum
- core_y  in  OUT_W  core result, valid the cycle after the last shift
- out_valid  out  1  result held in the output register
- out_ready  in  1  downstream accepts
- out_data  out  OUT_W  filtered sample
- busy  out  1  FSM not in IDLE
- sample_cnt  out  16  results delivered since reset or flush, wraps at 65535→0

## Operation
- FSM states are IDLE, LOAD, SHIFT and DONE.
- **IDLE:** if the FIFO is non-empty, pop the head into x_reg and go to LOAD.
- **LOAD (1 cycle):**
  - core_load=1; core_x=x_reg.
  - bit counter cleared. Next state is SHIFT.
- **SHIFT (DATA_W cycles):**
  - core_shift=1; core_bit_idx counts 0..DATA_W-1.
  - core_msb=1 only when core_bit_idx=DATA_W-1.
  - After the last bit, go to DONE.
- **DONE:**
  - Capture condition: when !out_valid || out_ready, latch core_y into out_data, set out_valid, and increment sample_cnt.
  - After capturing: if the FIFO is non-empty, pop it and go to LOAD; otherwise go to IDLE.
  - If the capture condition fails, stay in DONE (stall). core_y is guaranteed stable by the core while no new core_load is issued.
- **Output port:** out_valid clears on out_ready when no new capture occurs the same cycle. A capture and an acceptance in the same cycle keep out_valid=1 with the new data.
- **FIFO:**
  - Push when in_valid && in_ready; pop as above.
  - A push and a pop in the same cycle are both legal at any occupancy except when full; in_ready is low when full, so no push occurs.
  - Pointers wrap modulo FIFO_DEPTH.
- **flush:**
  - Empties the FIFO, clears out_valid and sample_cnt, and returns the FSM to IDLE next cycle. Any in-flight sample is discarded.
  - A push in the flush cycle is dropped.
- **Arithmetic:** no arithmetic on samples; widths pass straight through. The sample counter is a 16-bit unsigned counter with natural wrap.

## Timing
- **Reset values:**
  - state=IDLE; in_ready=1; out_valid=0; out_data=0.
  - core_load=0; core_shift=0; core_msb=0; core_bit_idx=0; core_x=0.
  - busy=0; sample_cnt=0; FIFO empty.
- **Latency:** sample accepted at cycle t into an empty, idle sequencer:
  - IDLE pop at t+1, LOAD at t+2, SHIFT at t+3..t+2+DATA_W, DONE at t+3+DATA_W.
  - out_valid=1 at t+4+DATA_W, i.e. t+12 for DATA_W=8.
- **Throughput:** with the FIFO kept non-empty and out_ready=1, one result every DATA_W+2 = 10 cycles. DONE→LOAD is direct, with no IDLE cycle.
- **Outputs:** all outputs are registered or decoded from registered state; no combinational path from in_valid or out_ready to any output except in_ready.
- **Reset mid-operation:** asynchronous return to the reset values within the same cycle; the FIFO contents are lost.

## Test plan
- **Single sample:** reset, then push 8'd127 once.
  - core_load pulses once with core_x=127.
  - Eight core_shift cycles follow, core_msb only on idx 7.
  - out_valid rises exactly 12 cycles after acceptance, with out_data equal to the core_y model; sample_cnt=1.
- **Back-to-back streaming:** push 177 samples from a sine table with out_ready=1.
  - core_load pulses are spaced exactly 10 cycles apart.
  - 177 results arrive in order; sample_cnt=177.
- **Backpressure:** hold out_ready=0 while pushing 6 samples.
  - After the first result, the FSM stalls in DONE.
  - in_ready drops once 4 samples are queued; no sample is lost or duplicated.
  - Release out_ready: all 6 results emerge in order.
- **Full/empty boundary:** with the FIFO full, assert in_valid in the same cycle as a DONE→LOAD pop.
  - The push is rejected (in_ready=0 in that cycle).
  - The next cycle shows in_ready=1 and the occupancy is 3.
- **Flush mid-SHIFT:** assert flush at core_bit_idx=3 with 2 samples queued.
  - Next cycle: IDLE, busy=0, in_ready=1, out_valid=0, sample_cnt=0.
  - No further core_load until a new push.
- **Async reset mid-operation:** drop RstN during SHIFT. All outputs take their reset values immediately, and a subsequent push of 8'd0 produces out_valid after 12 cycles.
